// File: rtl/baud_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : baud_gen_if
// Description : Control and status bundle for the baud-rate generator.
//               The master drives enable/sync/divisor; the slave (the
//               generator) returns the baud clock, ticks and phase.
// Revision    : 1.0 - initial release
// ============================================================================
interface baud_gen_if #(
  parameter int WIDTH = 22,
  parameter int OVS   = 16
);
  localparam int PW = $clog2(OVS);

  logic             en;
  logic             sync;
  logic [WIDTH-1:0] div;
  logic             ckd;
  logic             tick;
  logic             otick;
  logic [PW-1:0]    phase;

  modport master (
    output en, sync, div,
    input  ckd, tick, otick, phase
  );

  modport slave (
    input  en, sync, div,
    output ckd, tick, otick, phase
  );
endinterface
`default_nettype wire

// File: rtl/baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : baud_gen
// Description : Fractional-free baud clock generator. Divides ck by D to make
//               oversample ticks, counts OVS of them per baud period, and
//               produces a square baud clock, a per-period tick and the
//               oversample phase. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module baud_gen #(
  parameter int WIDTH = 22,
  parameter int OVS   = 16
) (
  input  wire logic   ck,
  input  wire logic   rst,
  baud_gen_if.slave   bus
);

  localparam int            PW         = $clog2(OVS);
  localparam logic [PW-1:0] c_PH_LAST  = PW'(OVS - 1);
  localparam logic [PW-1:0] c_PH_HALF  = PW'(OVS / 2);
  localparam logic [PW-1:0] c_PH_ONE   = PW'(1);
  localparam logic [WIDTH-1:0] c_ONE   = WIDTH'(1);

  logic [WIDTH-1:0] r_dcnt;
  logic [WIDTH-1:0] r_dsh;
  logic [PW-1:0]    r_phase;
  logic             r_ckd;
  logic             r_tick;
  logic             r_otick;

  logic [WIDTH-1:0] w_dlast;
  logic             w_adv;
  logic             w_wrap;
  logic [PW-1:0]    w_phase_nxt;

  // Terminal count D-1; a zero divisor shadow behaves as divide-by-one.
  assign w_dlast     = (r_dsh == '0) ? '0 : (r_dsh - c_ONE);
  assign w_adv       = (r_dcnt >= w_dlast);
  assign w_wrap      = w_adv && (r_phase == c_PH_LAST);
  // OVS is a power of two, so the natural PW-bit rollover is the modulo.
  assign w_phase_nxt = w_adv ? (r_phase + c_PH_ONE) : r_phase;

  // Divider, phase counter and registered outputs; idle beats sync beats count.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_dcnt  <= '0;
      r_dsh   <= '0;
      r_phase <= '0;
      r_ckd   <= 1'b1;
      r_tick  <= 1'b0;
      r_otick <= 1'b0;
    end else if (!bus.en) begin
      r_dcnt  <= '0;
      r_dsh   <= bus.div;
      r_phase <= '0;
      r_ckd   <= 1'b1;
      r_tick  <= 1'b0;
      r_otick <= 1'b0;
    end else if (bus.sync) begin
      r_dcnt  <= '0;
      r_dsh   <= bus.div;
      r_phase <= '0;
      r_ckd   <= 1'b0;
      r_tick  <= 1'b0;
      r_otick <= 1'b0;
    end else begin
      r_dcnt  <= w_adv ? '0 : (r_dcnt + c_ONE);
      r_otick <= w_adv;
      r_phase <= w_phase_nxt;
      r_tick  <= w_wrap;
      r_ckd   <= (w_phase_nxt >= c_PH_HALF);
      // Divisor changes take effect only at a baud boundary, where dcnt is 0.
      if (w_wrap) begin
        r_dsh <= bus.div;
      end
    end
  end

  assign bus.ckd   = r_ckd;
  assign bus.tick  = r_tick;
  assign bus.otick = r_otick;
  assign bus.phase = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_baud_gen
// Description : Self-checking bench for baud_gen. An arithmetic model tracks
//               the number of enabled edges since the start of each baud
//               period and derives every output from it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_baud_gen;

  localparam int OVS = 16;

  logic ck  = 1'b0;
  logic rst = 1'b0;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  baud_gen_if #(.WIDTH(22), .OVS(16)) bus  ();
  baud_gen_if #(.WIDTH(8),  .OVS(4))  bus2 ();

  baud_gen #(.WIDTH(22), .OVS(16)) dut  (.ck(ck), .rst(rst), .bus(bus));
  baud_gen #(.WIDTH(8),  .OVS(4))  dut2 (.ck(ck), .rst(rst), .bus(bus2));

  always #5 ck = ~ck;

  // Model state: m_k = enabled edges since period start, m_d = divisor in use.
  int   m_k;
  int   m_d;
  logic m_ckd;
  logic m_tick;
  logic m_otick;
  int   m_phase;

  function automatic int eff(input logic [21:0] d);
    return (d == 0) ? 1 : int'(d);
  endfunction

  // Behavioural reference: outputs follow from edge count k and divisor D.
  always @(posedge ck or posedge rst) begin
    if (rst) begin
      m_k <= 0; m_d <= 1; m_ckd <= 1'b1; m_tick <= 1'b0; m_otick <= 1'b0; m_phase <= 0;
    end else if (!bus.en) begin
      m_k <= 0; m_d <= eff(bus.div); m_ckd <= 1'b1; m_tick <= 1'b0; m_otick <= 1'b0; m_phase <= 0;
    end else if (bus.sync) begin
      m_k <= 0; m_d <= eff(bus.div); m_ckd <= 1'b0; m_tick <= 1'b0; m_otick <= 1'b0; m_phase <= 0;
    end else begin
      m_k     <= ((m_k + 1) == m_d * OVS) ? 0 : m_k + 1;
      m_otick <= ((m_k + 1) % m_d) == 0;
      m_phase <= ((m_k + 1) / m_d) % OVS;
      m_tick  <= (m_k + 1) == m_d * OVS;
      m_ckd   <= (((m_k + 1) / m_d) % OVS) >= OVS / 2;
      if ((m_k + 1) == m_d * OVS) m_d <= eff(bus.div);
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge ck) begin
    if (chk_on) begin
      cmp("ckd",   32'(bus.ckd),   32'(m_ckd));
      cmp("tick",  32'(bus.tick),  32'(m_tick));
      cmp("otick", 32'(bus.otick), 32'(m_otick));
      cmp("phase", 32'(bus.phase), 32'(m_phase));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge ck);
  endtask

  task automatic restart(input logic [21:0] d);
    bus.en  = 1'b0;
    bus.div = d;
    step(2);
    bus.en  = 1'b1;
  endtask

  initial begin
    int n_ot, n_tk, t1, t2, hi, otk, r;
    bus.en = 1'b0; bus.sync = 1'b0; bus.div = 22'd2;
    bus2.en = 1'b0; bus2.sync = 1'b0; bus2.div = 8'd255;
    #1 rst = 1'b1;
    #1 chk_on = 1'b1;
    step(2);
    cmp("rst_ckd", 32'(bus.ckd), 32'd1);
    cmp("rst_tick", 32'(bus.tick), 32'd0);
    cmp("rst_otick", 32'(bus.otick), 32'd0);
    cmp("rst_phase", 32'(bus.phase), 32'd0);
    rst = 1'b0;

    // Basic run with D=2, divisor changed to 3 mid-period.
    restart(22'd2);
    step(1);
    cmp("e1_ckd", 32'(bus.ckd), 32'd0);
    cmp("e1_otick", 32'(bus.otick), 32'd0);
    step(1);
    cmp("e2_otick", 32'(bus.otick), 32'd1);
    cmp("e2_phase", 32'(bus.phase), 32'd1);
    step(7);
    bus.div = 22'd3;
    step(7);
    cmp("e16_ckd", 32'(bus.ckd), 32'd1);
    cmp("e16_phase", 32'(bus.phase), 32'd8);
    step(15);
    cmp("e31_tick", 32'(bus.tick), 32'd0);
    step(1);
    cmp("e32_tick", 32'(bus.tick), 32'd1);
    step(47);
    cmp("e79_tick", 32'(bus.tick), 32'd0);
    step(1);
    cmp("e80_tick", 32'(bus.tick), 32'd1);

    // Sync pulse at E20.
    restart(22'd2);
    step(19);
    bus.sync = 1'b1;
    step(1);
    bus.sync = 1'b0;
    cmp("sync_phase", 32'(bus.phase), 32'd0);
    cmp("sync_ckd", 32'(bus.ckd), 32'd0);
    step(31);
    cmp("e51_tick", 32'(bus.tick), 32'd0);
    step(1);
    cmp("e52_tick", 32'(bus.tick), 32'd1);

    // Divide-by-one for div=0 and div=1.
    for (int d = 0; d < 2; d++) begin
      restart(22'(d));
      n_ot = 0; n_tk = 0;
      for (int i = 0; i < 32; i++) begin
        step(1);
        n_ot += int'(bus.otick);
        n_tk += int'(bus.tick);
      end
      cmp("d01_otick_cnt", 32'(n_ot), 32'd32);
      cmp("d01_tick_cnt", 32'(n_tk), 32'd2);
    end

    // Disable mid-period, then asynchronous reset between edges.
    restart(22'd2);
    step(12);
    bus.en = 1'b0;
    step(1);
    cmp("dis_ckd", 32'(bus.ckd), 32'd1);
    cmp("dis_otick", 32'(bus.otick), 32'd0);
    cmp("dis_phase", 32'(bus.phase), 32'd0);
    bus.en = 1'b1;
    step(32);
    cmp("pre_rst_tick", 32'(bus.tick), 32'd1);
    #2 rst = 1'b1;
    #1;
    cmp("arst_ckd", 32'(bus.ckd), 32'd1);
    cmp("arst_tick", 32'(bus.tick), 32'd0);
    cmp("arst_phase", 32'(bus.phase), 32'd0);
    step(1);
    rst = 1'b0;

    // Randomized traffic: divisor changes, sync pulses, enable drops, resets.
    for (int i = 0; i < 3000; i++) begin
      step(1);
      r = int'($urandom_range(0, 999));
      if (r < 20) bus.div = 22'($urandom_range(0, 4));
      bus.sync = (r >= 20 && r < 35);
      if (r >= 35 && r < 45) bus.en = 1'b0;
      else if (!bus.en && r < 300) bus.en = 1'b1;
      if (r == 999) begin
        #2 rst = 1'b1;
        @(negedge ck);
        rst = 1'b0;
      end
    end
    bus.en = 1'b0; bus.sync = 1'b0;

    // Narrow instance: WIDTH=8, OVS=4, div=255 gives a 1020-cycle period.
    step(2);
    bus2.en = 1'b1;
    t1 = -1; t2 = -1; hi = 0; otk = 0;
    for (int k = 1; k <= 2100; k++) begin
      step(1);
      if (bus2.tick) begin
        if (t1 < 0) t1 = k;
        else if (t2 < 0) t2 = k;
      end
      if (k > 1020 && k <= 2040) begin
        hi  += int'(bus2.ckd);
        otk += int'(bus2.otick);
      end
    end
    cmp("p_tick1", 32'(t1), 32'd1020);
    cmp("p_tick2", 32'(t2), 32'd2040);
    cmp("p_ckd_high", 32'(hi), 32'd510);
    cmp("p_otick_cnt", 32'(otk), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/baud_gen.md
BAUD_GEN -- requirements
Module: baud_gen

Interface
REQ-001 Parameter WIDTH, default 22, SHALL set the width of the divisor input and the divide counter.
REQ-002 Parameter OVS, default 16, SHALL set the oversample factor: the number of otick pulses per baud period; it SHALL be a power of two, >= 2.
REQ-003 ck  input  1  SHALL be the single system clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 en  input  1  SHALL enable the generator; 0 means idle.
REQ-006 sync  input  1  SHALL restart the baud period for receiver start-bit alignment.
REQ-007 div  input  WIDTH  SHALL give the ck cycles per oversample tick (D).
REQ-008 ckd  output  1  SHALL be the baud clock: a square wave that is high while idle.
REQ-009 tick  output  1  SHALL pulse for one cycle at each baud-period boundary.
REQ-010 otick  output  1  SHALL pulse for one cycle at each oversample boundary.
REQ-011 phase  output  log2(OVS)  SHALL be the current oversample index within the baud period.

Function
REQ-012 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-013 Internal state SHALL consist of:
- dcnt (WIDTH bits): the divide counter;
- phase: the oversample index;
- dsh (WIDTH bits): the divisor shadow register.
REQ-014 The effective divisor SHALL be D = dsh, except that dsh = 0 SHALL be treated as D = 1.
REQ-015 While en = 0, each edge SHALL set dcnt = 0, phase = 0, ckd = 1, tick = 0, otick = 0 and dsh = div.
REQ-016 While en = 1 and sync = 0, each edge SHALL perform the following:
- if dcnt >= D-1: dcnt <= 0, otick <= 1, phase <= phase+1 (modulo OVS);
- otherwise: dcnt <= dcnt+1, otick <= 0.
REQ-017 tick SHALL be 1 for exactly the cycle after the edge on which phase wraps from OVS-1 to 0, and 0 otherwise.
REQ-018 dsh SHALL reload from div only on the edge where phase wraps from OVS-1 to 0, so that a div change never alters a baud period already in progress.
REQ-019 ckd SHALL be registered as 0 when the next phase is < OVS/2 and as 1 when the next phase is >= OVS/2, for every edge with en = 1.
REQ-020 In steady state, the baud period SHALL be D*OVS cycles, with ckd low for D*OVS/2 cycles and high for D*OVS/2 cycles.
REQ-021 The first low half after en rises SHALL last D*OVS/2 - 1 cycles, because ckd falls on the first enabled edge.
REQ-022 With D = 1, otick SHALL stay high continuously while enabled, and tick SHALL fire every OVS cycles.
REQ-023 When en = 1 and sync = 1, the edge SHALL set dcnt = 0, phase = 0, ckd = 0, tick = 0, otick = 0 and dsh = div, and counting SHALL resume on the next edge as if freshly enabled.
REQ-024 When en = 0, sync SHALL be ignored.
REQ-025 Priority SHALL be rst over en = 0 over sync over normal counting.
REQ-026 When en falls mid-period, the next edge SHALL force the idle state of REQ-015, with no partial tick.
REQ-027 dcnt SHALL never exceed D-1 after any edge, and phase SHALL wrap cleanly with no overflow.

Reset
REQ-028 While rst = 1, the block SHALL hold dcnt = 0, phase = 0, dsh = 0, ckd = 1, tick = 0 and otick = 0, independent of ck.
REQ-029 After rst deasserts, the block SHALL follow REQ-015 or REQ-016 on the next edge according to en.
REQ-030 When rst asserts mid-period, the outputs SHALL take their reset values immediately, with no wait for a ck edge.

Verification
REQ-031 The bench SHALL cover each of the following directed scenarios:
- Basic: div = 2, OVS = 16, en rises before E1 -> otick after E2, E4, ...; ckd = 0 after E1 and 1 after E16; tick after E32; then ckd low 16 / high 16 with a 32-cycle period.
- Divisor change: div changed from 2 to 3 at E10 -> the period ending at E32 is unchanged, and the next period is 48 cycles.
- div = 0 and div = 1: both -> otick constantly high while enabled, and tick every 16 cycles.
- sync: sync pulsed at E20 with div = 2 -> phase = 0 and ckd = 0 after E20; next tick after E52.
- Disable and reset: en dropped at E12 -> ckd = 1, otick = 0, phase = 0 after E13; rst asserted asynchronously between edges -> ckd = 1 and tick = 0 immediately.
- Parameters: WIDTH = 8, OVS = 4, div = 255 -> baud period 1020 cycles, and no counter overflow.
